// File: rtl/adder_tree_pkg.sv
// Shared definitions for the adder tree scheduler.
// Holds the FSM state encoding and a helper that derives the tree pipeline latency.
package adder_tree_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  // A LEN-input tree has clog2(LEN) adder levels; levels at or beyond
  // piping_start_stage carry a pipeline register.
  function automatic int tree_lat_f(input int len, input int piping_start_stage);
    int levels;
    levels = (len > 1) ? $clog2(len) : 0;
    if (levels > piping_start_stage) begin
      return levels - piping_start_stage;
    end
    return 0;
  endfunction

endpackage

// File: rtl/DelayNUnit.sv
// Fixed-depth shift register with synchronous clear.
// Every stage is cleared by reset so nothing in flight survives it.
module DelayNUnit #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign stage_d[gi] = din;
      end else begin : g_tail
        assign stage_d[gi] = stage_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset) begin
        stage_q[i] <= '0;
      end else begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/adder_tree_scheduler.sv
// Sequences CHUNKS chunks through a pipelined adder tree and accumulates the
// returned partial sums into one job result, held until the consumer takes it.
module adder_tree_scheduler
  import adder_tree_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHUNKS   = 4,
  parameter int TREE_LAT = 2,
  localparam int SEL_W   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             feed_ok,
  input  logic [WIDTH-1:0] tree_sum,
  input  logic             out_ready,
  output logic [SEL_W-1:0] chunk_sel,
  output logic             chunk_valid,
  output logic             busy,
  output logic [WIDTH-1:0] acc_out,
  output logic             out_valid
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CHUNKS - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ret_cnt_q, ret_cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             ret_valid;
  logic             ret_take;
  logic             last_ret;

  assign chunk_valid = (state_q == ST_ISSUE) && feed_ok;

  // The valid bit travels alongside the data through the tree.
  generate
    if (TREE_LAT > 0) begin : g_delay
      DelayNUnit #(
        .WIDTH(1),
        .DEPTH(TREE_LAT)
      ) u_valid_delay (
        .clk  (clk),
        .reset(reset),
        .din  (chunk_valid),
        .dout (ret_valid)
      );
    end else begin : g_bypass
      assign ret_valid = chunk_valid;
    end
  endgenerate

  // Returns only count while a job is active, so stray valids in IDLE/HOLD are inert.
  assign ret_take = ret_valid && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));
  assign last_ret = ret_take && (ret_cnt_q == LAST_IDX);

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ret_cnt_d = ret_cnt_q;
    acc_d     = acc_q;

    if (ret_take) begin
      acc_d     = (ret_cnt_q == '0) ? tree_sum : acc_q + tree_sum;
      ret_cnt_d = ret_cnt_q + SEL_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_ISSUE;
          sel_d     = '0;
          ret_cnt_d = '0;
          acc_d     = '0;
        end
      end
      ST_ISSUE: begin
        if (chunk_valid) begin
          if (sel_q == LAST_IDX) begin
            sel_d   = '0;
            // With no tree latency the final sum returns alongside the final issue.
            state_d = last_ret ? ST_HOLD : ST_DRAIN;
          end else begin
            sel_d = sel_q + SEL_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (last_ret) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    out_valid_d = (state_d == ST_HOLD);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      ret_cnt_q   <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      ret_cnt_q   <= ret_cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign chunk_sel = sel_q;
  assign acc_out   = acc_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_adder_tree_scheduler.sv
// Directed, table-driven bench for adder_tree_scheduler: a default instance
// (CHUNKS=4, TREE_LAT=2) with a small tree model, and a CHUNKS=1/TREE_LAT=0 instance.
module tb_adder_tree_scheduler;

  localparam int MAXC = 20;

  typedef struct packed {
    logic [3:0][15:0] sums;
    logic [31:0]      feed;
    logic [7:0]       hold;
    logic [15:0]      exp_acc;
    logic [31:0]      exp_cv;
    logic [7:0]       exp_ov;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, feed_ok, out_ready;
  logic [15:0] tree_sum;
  logic [1:0]  chunk_sel;
  logic        chunk_valid, busy, out_valid;
  logic [15:0] acc_out;

  logic        start1, feed1, ready1;
  logic [15:0] tree_sum1;
  logic [0:0]  chunk_sel1;
  logic        chunk_valid1, busy1, out_valid1;
  logic [15:0] acc_out1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0][15:0] sums_cur;
  logic             p1_v, p2_v;
  logic [1:0]       p1_s, p2_s;
  vec_t             vecs [7];

  always #5 clk = ~clk;

  adder_tree_scheduler #(.WIDTH(16), .CHUNKS(4), .TREE_LAT(2)) dut (
    .clk(clk), .reset(reset), .start(start), .feed_ok(feed_ok),
    .tree_sum(tree_sum), .out_ready(out_ready), .chunk_sel(chunk_sel),
    .chunk_valid(chunk_valid), .busy(busy), .acc_out(acc_out), .out_valid(out_valid)
  );

  adder_tree_scheduler #(.WIDTH(16), .CHUNKS(1), .TREE_LAT(0)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .feed_ok(feed1),
    .tree_sum(tree_sum1), .out_ready(ready1), .chunk_sel(chunk_sel1),
    .chunk_valid(chunk_valid1), .busy(busy1), .acc_out(acc_out1), .out_valid(out_valid1)
  );

  // Two-stage tree model: the sum of the chunk presented two cycles earlier.
  always @(posedge clk) begin
    p1_v <= chunk_valid;
    p1_s <= chunk_sel;
    p2_v <= p1_v;
    p2_s <= p1_s;
  end
  assign tree_sum  = p2_v ? sums_cur[p2_s] : 16'hDEAD;
  assign tree_sum1 = 16'hFFFB;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  // Entered at posedge+1 of an IDLE cycle (cycle 0); returns at posedge+1 of the
  // IDLE cycle after release, so consecutive calls exercise back-to-back jobs.
  task automatic run_job(input vec_t v, input int id);
    int          cyc;
    int          first;
    int          nsel;
    logic [31:0] obs_cv;
    logic [7:0]  sel_seq;
    logic [15:0] acc_seen;
    cyc = 0; first = -1; nsel = 0; obs_cv = '0; sel_seq = '0; acc_seen = '0;
    sums_cur = v.sums;
    while (first < 0 && cyc <= MAXC) begin
      start     = (cyc == 0);
      feed_ok   = v.feed[cyc];
      out_ready = 1'b0;
      @(negedge clk);
      if (cyc == 0) chk("idle_outputs", {27'd0, busy, out_valid, chunk_valid, chunk_sel}, 32'd0);
      if (cyc == 1) chk("busy_in_issue", {31'd0, busy}, 32'd1);
      if (chunk_valid) begin
        obs_cv[cyc] = 1'b1;
        if (nsel < 4) sel_seq[nsel*2 +: 2] = chunk_sel;
        nsel++;
      end
      if (out_valid) begin
        first    = cyc;
        acc_seen = acc_out;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("chunk_valid_cycles", obs_cv, v.exp_cv);
    chk("chunk_sel_order", {24'd0, sel_seq}, 32'h0000_00E4);
    chk("out_valid_cycle", first, {24'd0, v.exp_ov});
    chk("acc_out", {16'd0, acc_seen}, {16'd0, v.exp_acc});
    for (int h = 0; h < int'(v.hold); h++) begin
      start     = (h == 2);
      out_ready = 1'b0;
      @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_acc", {16'd0, acc_out}, {16'd0, v.exp_acc});
      @(posedge clk); #1;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    $display("job %0d: acc_out=0x%04h out_valid_cycle=%0d chunk_valid_mask=0x%0h", id, acc_seen, first, obs_cv);
  endtask

  initial begin
    vecs[0] = '{sums: {16'd40, 16'd30, 16'd20, 16'd10}, feed: 32'hFFFF_FFFF, hold: 8'd0,
                exp_acc: 16'd100, exp_cv: 32'h1E, exp_ov: 8'd7};
    vecs[1] = '{sums: {16'd40, 16'd30, 16'd20, 16'd10}, feed: 32'hFFFF_FFF3, hold: 8'd0,
                exp_acc: 16'd100, exp_cv: 32'h72, exp_ov: 8'd9};
    vecs[2] = '{sums: {16'd40, 16'd30, 16'd20, 16'd10}, feed: 32'hFFFF_FFFF, hold: 8'd5,
                exp_acc: 16'd100, exp_cv: 32'h1E, exp_ov: 8'd7};
    vecs[3] = '{sums: {16'd0, 16'd0, 16'h0001, 16'h7FFF}, feed: 32'hFFFF_FFFF, hold: 8'd0,
                exp_acc: 16'h8000, exp_cv: 32'h1E, exp_ov: 8'd7};
    vecs[4] = '{sums: {16'd5, 16'd3, 16'hFFFE, 16'hFFFF}, feed: 32'hFFFF_FFFF, hold: 8'd1,
                exp_acc: 16'd5, exp_cv: 32'h1E, exp_ov: 8'd7};
    vecs[5] = '{sums: {16'd400, 16'd300, 16'd200, 16'd100}, feed: 32'hFFFF_FFAA, hold: 8'd0,
                exp_acc: 16'd1000, exp_cv: 32'hAA, exp_ov: 8'd10};
    vecs[6] = '{sums: {16'd4, 16'd3, 16'd2, 16'd1}, feed: 32'hFFFF_FFFF, hold: 8'd0,
                exp_acc: 16'd10, exp_cv: 32'h1E, exp_ov: 8'd7};

    // Reset must dominate every other input.
    reset = 1'b1; start = 1'b1; feed_ok = 1'b1; out_ready = 1'b1;
    start1 = 1'b1; feed1 = 1'b1; ready1 = 1'b1;
    sums_cur = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {10'd0, chunk_sel, chunk_valid, busy, out_valid, acc_out}, 32'd0);
    chk("reset_outputs_1", {12'd0, chunk_sel1, chunk_valid1, busy1, out_valid1, acc_out1}, 32'd0);
    reset = 1'b0; start = 1'b0; out_ready = 1'b0; start1 = 1'b0; ready1 = 1'b0;

    for (int i = 0; i < 6; i++) run_job(vecs[i], i);

    // Reset during the third ISSUE cycle, then restart straight away.
    sums_cur = vecs[6].sums;
    start = 1'b1; feed_ok = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_job_reset", {10'd0, chunk_sel, chunk_valid, busy, out_valid, acc_out}, 32'd0);
    $display("reset mid-job: chunk_sel=%0d busy=%0d out_valid=%0d acc_out=0x%04h", chunk_sel, busy, out_valid, acc_out);
    reset = 1'b0;
    run_job(vecs[6], 6);

    // Single chunk, no tree latency, negative sum.
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    @(negedge clk);
    chk("lat0_issue", {29'd0, chunk_valid1, out_valid1, busy1}, 32'b101);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat0_valid", {31'd0, out_valid1}, 32'd1);
    chk("lat0_acc", {16'd0, acc_out1}, 32'h0000_FFFB);
    $display("lat0 job: acc_out=0x%04h out_valid=%0d", acc_out1, out_valid1);
    ready1 = 1'b1;
    @(posedge clk); #1;
    ready1 = 1'b0;
    @(negedge clk);
    chk("lat0_release", {30'd0, out_valid1, busy1}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_tree_scheduler.md
ADDER_TREE_SCHEDULER -- requirements
Module: adder_tree_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/sum width (matches adder tree WIDTH).
REQ-002 SHALL have parameter CHUNKS, default 4, number of LEN-element chunks summed per job (>=1).
REQ-003 SHALL have parameter TREE_LAT, default 2, pipeline register count of the driven adder tree (>=0).
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock, all state updates on rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 start  input  1  job request, accepted only in IDLE.
REQ-008 feed_ok  input  1  chunk source has current chunk_sel data ready this cycle.
REQ-009 tree_sum  input  WIDTH  adder tree output, signed.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 chunk_sel  output  max(1,$clog2(CHUNKS))  index of chunk presented to tree.
REQ-012 chunk_valid  output  1  chunk_sel data enters tree this cycle.
REQ-013 busy  output  1  high in any state except IDLE.
REQ-014 acc_out  output  WIDTH  accumulated job result, signed.
REQ-015 out_valid  output  1  acc_out valid, held until out_ready.

Function
REQ-016 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> HOLD -> IDLE.
REQ-017 IDLE: start=1 -> ISSUE next cycle; accumulator and issue/return counters cleared same edge.
REQ-018 ISSUE: chunk_valid = feed_ok; chunk_sel increments only on cycles with chunk_valid=1; after issuing chunk CHUNKS-1 -> DRAIN.
REQ-019 feed_ok=0 in ISSUE SHALL hold chunk_sel and insert a bubble; no chunk skipped or repeated.
REQ-020 chunk_valid SHALL be delayed exactly TREE_LAT cycles to form ret_valid; tree_sum sampled on edges where ret_valid=1 (TREE_LAT=0: same cycle).
REQ-021 First returned sum of a job SHALL load the accumulator; subsequent sums add, modulo 2^WIDTH (wrap, no saturation, no flag).
REQ-022 DRAIN: after CHUNKS returned sums -> HOLD; out_valid=1 and acc_out stable from next cycle.
REQ-023 Latency with feed_ok=1: start sampled at cycle 0 -> chunk_valid cycles 1..CHUNKS -> out_valid first high in cycle CHUNKS+TREE_LAT+1.
REQ-024 HOLD: out_valid and acc_out held while out_ready=0; out_valid=1 and out_ready=1 -> IDLE next cycle, out_valid=0.
REQ-025 start while busy=1 SHALL be ignored (not queued).
REQ-026 start in the IDLE cycle following HOLD release SHALL be accepted (back-to-back jobs, one idle cycle minimum).
REQ-027 chunk_valid SHALL be 0 outside ISSUE; chunk_sel SHALL be 0 in IDLE.

Reset
REQ-028 reset=1 at a clock edge SHALL force IDLE, chunk_sel=0, chunk_valid=0, busy=0, acc_out=0, out_valid=0, clear the valid delay line and all counters, regardless of state.
REQ-029 reset SHALL dominate start, feed_ok and out_ready in the same cycle.
REQ-030 Sums in flight when reset is asserted SHALL be discarded; no partial result appears after reset.

Structure
REQ-031 Shared package adder_tree_pkg SHALL hold the FSM state encoding and a function computing TREE_LAT from LEN and piping_start_stage (count of pipeline stages in the tree).
REQ-032 The valid delay line SHALL instantiate existing sub-module DelayNUnit (width 1, depth TREE_LAT), bypassed when TREE_LAT=0.

Verification
REQ-033 CHUNKS=4, TREE_LAT=2, feed_ok=1, tree_sum per chunk 10,20,30,40 -> acc_out=100, out_valid first high cycle 7.
REQ-034 Same, feed_ok=0 on cycles 2-3 -> chunk_valid on cycles 1,4,5,6, chunk_sel 0,1,2,3, acc_out=100, out_valid first high cycle 9.
REQ-035 out_ready=0 for 5 cycles in HOLD, start pulsed meanwhile -> out_valid and acc_out=100 held, start ignored, IDLE one cycle after out_ready=1.
REQ-036 Sums 0x7FFF,0x0001,0,0 -> acc_out=0x8000 (wrap).
REQ-037 reset on cycle 3 of ISSUE -> next cycle all outputs 0, IDLE; new job with sums 1,2,3,4 -> acc_out=10, no stale contribution.
REQ-038 TREE_LAT=0, CHUNKS=1, tree_sum=-5 -> acc_out=0xFFFB, out_valid first high cycle 2.
